// File: rtl/mul_result_buffer_pkg.sv
// Shared types for the multiplier result path: result uop, branch broadcast,
// sequence number / tag widths, and the age-compare helper used for kills.
package mul_result_buffer_pkg;

   localparam int SQN_W = 7;
   localparam int TAG_W = 7;
   localparam int RES_W = 32;

   typedef logic [SQN_W-1:0] SqN;
   typedef logic [TAG_W-1:0] Tag;
   typedef logic [3:0]       Flags;

   localparam Flags FLAGS_NONE     = 4'd0;
   localparam Flags FLAGS_BRK      = 4'd1;
   localparam Flags FLAGS_TRAP     = 4'd2;
   localparam Flags FLAGS_EXCEPT   = 4'd3;
   localparam Flags FLAGS_ORDERING = 4'd4;

   typedef struct packed {
      logic [RES_W-1:0] result;
      Tag               tagDst;
      SqN               sqN;
      Flags             flags;
      logic             doNotCommit;
      logic             valid;
   } RES_UOp;

   typedef struct packed {
      SqN   sqN;
      logic taken;
   } BranchProv;

   // True when a uop with sequence number s is younger than a taken branch
   // (wrap-safe signed distance) and must therefore be squashed.
   function automatic logic is_killed(input BranchProv br, input SqN s);
      SqN d;
      d = s - br.sqN;
      return br.taken && ($signed(d) > 0);
   endfunction

endpackage

// File: rtl/mul_result_buffer.sv
// Collapsing result queue behind the pipelined multiplier. Absorbs a
// non-stallable result stream, drops branch-killed entries, presents the
// oldest survivor from slot 0 flops and throttles issue via OUT_busy.
module mul_result_buffer
   import mul_result_buffer_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int IN_FLIGHT = 3
)(
   input  logic      clk,
   input  logic      rst,
   input  BranchProv IN_branch,
   input  RES_UOp    IN_uop,
   input  logic      IN_wbStall,
   output RES_UOp    OUT_uop,
   output logic      OUT_busy
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   RES_UOp           r_slots [DEPTH];
   RES_UOp           w_next  [DEPTH];
   logic [DEPTH-1:0] w_vld;
   logic [CNT_W-1:0] w_count;
   logic             w_consume;
   logic             w_overflow;

   function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < DEPTH; i++) c = c + CNT_W'(v[i]);
      return c;
   endfunction

   // Gather the registered slot valid bits for occupancy.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) w_vld[i] = r_slots[i].valid;
   end

   assign w_count  = popcount(w_vld);
   // Registered-only path: issue sees occupancy, never the current inputs.
   assign OUT_busy = (w_count >= CNT_W'(DEPTH - IN_FLIGHT));
   assign OUT_uop  = r_slots[0];

   // Next state: drop consumed head, kill young entries, collapse, append.
   always_comb begin
      int n_keep;
      n_keep     = 0;
      w_consume  = r_slots[0].valid && !IN_wbStall;
      w_overflow = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         w_next[i]       = r_slots[i];
         w_next[i].valid = 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (r_slots[i].valid && !((i == 0) && w_consume) &&
             !is_killed(IN_branch, r_slots[i].sqN)) begin
            w_next[n_keep[IDX_W-1:0]] = r_slots[i];
            n_keep = n_keep + 1;
         end
      end
      if (IN_uop.valid && !is_killed(IN_branch, IN_uop.sqN)) begin
         if (n_keep < DEPTH) w_next[n_keep[IDX_W-1:0]] = IN_uop;
         else                w_overflow = 1'b1;
      end
   end

   // Slot storage; reset clears only the valid bits, payload is don't-care.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_slots[i].valid <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) r_slots[i] <= w_next[i];
      end
   end

   // An arrival with no free slot means issue ignored OUT_busy.
   always_ff @(posedge clk) begin
      if (!rst) assert (!w_overflow);
   end

endmodule

// File: tb/tb_mul_result_buffer.sv
// Directed bench for mul_result_buffer: stimulus pushes expected results into
// a scoreboard queue; an independent monitor pops and compares every consumed
// OUT_uop. Direct checks cover latency, busy, head contents and reset.
module tb_mul_result_buffer;
   import mul_result_buffer_pkg::*;

   logic      clk = 1'b0;
   logic      rst;
   BranchProv IN_branch;
   RES_UOp    IN_uop;
   logic      IN_wbStall;
   RES_UOp    OUT_uop;
   logic      OUT_busy;

   int        n_checks = 0;
   int        n_err    = 0;
   RES_UOp    sb_q[$];
   RES_UOp    mon_exp;

   mul_result_buffer #(.DEPTH(4), .IN_FLIGHT(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .IN_branch (IN_branch),
      .IN_uop    (IN_uop),
      .IN_wbStall(IN_wbStall),
      .OUT_uop   (OUT_uop),
      .OUT_busy  (OUT_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int sqn, input int tag, input int res, input bit exp_out);
      RES_UOp u;
      u.valid       = 1'b1;
      u.sqN         = SqN'(sqn);
      u.tagDst      = Tag'(tag);
      u.result      = res;
      u.flags       = Flags'(sqn);
      u.doNotCommit = sqn[0];
      IN_uop        = u;
      if (exp_out) sb_q.push_back(u);
   endtask

   task automatic issue_std(input int sqn, input bit exp_out);
      issue(sqn, sqn + 16, 32'hA000 + sqn * 3, exp_out);
   endtask

   // Monitor: every consumed head must match the oldest expected result.
   always @(negedge clk) begin
      if (!rst && OUT_uop.valid && !IN_wbStall) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: got sqN %0d expected no output", OUT_uop.sqN);
         end else begin
            mon_exp = sb_q.pop_front();
            if (OUT_uop !== mon_exp) begin
               n_err++;
               $display("FAIL sb_data: got %h expected %h", OUT_uop, mon_exp);
            end
         end
      end
   end

   initial begin
      rst        = 1'b1;
      IN_branch  = '0;
      IN_uop     = '0;
      IN_wbStall = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("reset_valid", 64'(OUT_uop.valid), 64'd0);
      chk("reset_busy", 64'(OUT_busy), 64'd0);

      // Passthrough: one-cycle latency, no combinational path
      issue(5, 12, 32'h1234, 1'b1);
      chk("pt_no_comb", 64'(OUT_uop.valid), 64'd0);
      chk("pt_busy_t", 64'(OUT_busy), 64'd0);
      tick();
      IN_uop.valid = 1'b0;
      chk("pt_valid_t1", 64'(OUT_uop.valid), 64'd1);
      chk("pt_sqn", 64'(OUT_uop.sqN), 64'd5);
      chk("pt_tag", 64'(OUT_uop.tagDst), 64'd12);
      chk("pt_res", 64'(OUT_uop.result), 64'h1234);
      chk("pt_busy_t1", 64'(OUT_busy), 64'd1);
      tick();
      chk("pt_valid_t2", 64'(OUT_uop.valid), 64'd0);
      chk("pt_busy_t2", 64'(OUT_busy), 64'd0);

      // Stall fill, then drain in order
      IN_wbStall = 1'b1;
      issue_std(1, 1'b1);
      tick();
      chk("fill_busy_1", 64'(OUT_busy), 64'd1);
      chk("fill_head_1", 64'(OUT_uop.sqN), 64'd1);
      for (int k = 2; k <= 4; k++) begin
         issue_std(k, 1'b1);
         tick();
      end
      IN_uop.valid = 1'b0;
      chk("fill_head_hold", 64'(OUT_uop.sqN), 64'd1);
      tick();
      chk("fill_head_hold2", 64'(OUT_uop.sqN), 64'd1);
      chk("fill_busy_full", 64'(OUT_busy), 64'd1);
      IN_wbStall = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("drain_valid", 64'(OUT_uop.valid), 64'd1);
         chk("drain_sqn", 64'(OUT_uop.sqN), 64'(k + 1));
         tick();
      end
      chk("drain_empty", 64'(OUT_uop.valid), 64'd0);

      // Flush collapse: 3,9,4,11 with branch sqN=5 leaves 3,4
      IN_wbStall = 1'b1;
      issue_std(3, 1'b1);  tick();
      issue_std(9, 1'b0);  tick();
      issue_std(4, 1'b1);  tick();
      issue_std(11, 1'b0); tick();
      IN_uop.valid = 1'b0;
      IN_branch    = '{sqN: SqN'(5), taken: 1'b1};
      tick();
      IN_branch.taken = 1'b0;
      chk("fl_head", 64'(OUT_uop.sqN), 64'd3);
      chk("fl_busy", 64'(OUT_busy), 64'd1);
      IN_wbStall = 1'b0;
      tick();
      chk("fl_second", 64'(OUT_uop.sqN), 64'd4);
      tick();
      chk("fl_empty", 64'(OUT_uop.valid), 64'd0);

      // Flush with arrival and head consume: 2,4,9,6 + branch 7 + arrival 8
      IN_wbStall = 1'b1;
      issue_std(2, 1'b1); tick();
      issue_std(4, 1'b1); tick();
      issue_std(9, 1'b0); tick();
      issue_std(6, 1'b1); tick();
      IN_wbStall = 1'b0;
      IN_branch  = '{sqN: SqN'(7), taken: 1'b1};
      issue_std(8, 1'b0);
      tick();
      IN_branch.taken = 1'b0;
      IN_uop.valid    = 1'b0;
      chk("fa_head", 64'(OUT_uop.sqN), 64'd4);
      tick();
      chk("fa_second", 64'(OUT_uop.sqN), 64'd6);
      tick();
      chk("fa_empty", 64'(OUT_uop.valid), 64'd0);

      // Full steady state: consume + arrival every cycle at count=4
      IN_wbStall = 1'b1;
      for (int k = 20; k < 24; k++) begin
         issue_std(k, 1'b1);
         tick();
      end
      IN_wbStall = 1'b0;
      for (int k = 0; k < 10; k++) begin
         issue_std(24 + k, 1'b1);
         chk("ss_busy", 64'(OUT_busy), 64'd1);
         chk("ss_head", 64'(OUT_uop.sqN), 64'(20 + k));
         tick();
      end
      IN_uop.valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("ss_drain", 64'(OUT_uop.sqN), 64'(30 + k));
         tick();
      end
      chk("ss_empty", 64'(OUT_uop.valid), 64'd0);

      // Reset mid-stall with an arrival during reset
      IN_wbStall = 1'b1;
      for (int k = 40; k < 43; k++) begin
         issue_std(k, 1'b1);
         tick();
      end
      IN_uop.valid = 1'b0;
      chk("rs_busy_pre", 64'(OUT_busy), 64'd1);
      rst = 1'b1;
      issue_std(43, 1'b0);
      tick();
      rst          = 1'b0;
      IN_uop.valid = 1'b0;
      sb_q.delete();
      chk("rs_valid", 64'(OUT_uop.valid), 64'd0);
      chk("rs_busy", 64'(OUT_busy), 64'd0);
      IN_wbStall = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rs_no_out", 64'(OUT_uop.valid), 64'd0);
      end

      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
